// File: rtl/pong_collision_detector.sv
// pong_collision_detector
//   Collision stage that feeds the ball FSM. Once per frame_tick it compares
//   the ball bounding box against the screen walls, both paddles and both
//   goal lines, emits a one-tick bounce code, keeps both scores and sequences
//   the serve and game-over phases.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   frame_tick          one-cycle update strobe, shared with the ball FSM
//   ball_x, ball_y      ball left column / top row
//   ball_size_x/_y      ball width / height
//   left_paddle_y       left paddle top row
//   right_paddle_y      right paddle top row
//   bounce              00 none, 01 paddle, 10 wall, 11 goal/re-serve
//   score_left/_right   player scores (saturate at MAX_SCORE)
//   serving             high while in SERVE
//   game_over           high while in OVER
//   debug_state         current FSM state (PLAY/HOLD/SERVE/OVER)
//
// Handshake: there is no valid/ready pair here. frame_tick is the only
// qualifier; every output is registered and changes only on a frame_tick
// cycle (or on reset), so the ball FSM samples each bounce code exactly once.

module pong_collision_detector #(
  parameter int SCREEN_X       = 640,
  parameter int SCREEN_Y       = 480,
  parameter int PADDLE_W       = 10,
  parameter int PADDLE_H       = 80,
  parameter int LEFT_PADDLE_X  = 20,
  parameter int RIGHT_PADDLE_X = 610,
  parameter int HOLDOFF        = 8,
  parameter int SERVE_DELAY    = 60,
  parameter int MAX_SCORE      = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_size_x,
  input  logic [7:0] ball_size_y,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [1:0] bounce,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       serving,
  output logic       game_over,
  output logic [1:0] debug_state
);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] B_NONE   = 2'b00;
  localparam logic [1:0] B_PADDLE = 2'b01;
  localparam logic [1:0] B_WALL   = 2'b10;
  localparam logic [1:0] B_GOAL   = 2'b11;

  logic [1:0] state;
  logic [7:0] holdoff_cnt;
  logic [7:0] serve_cnt;

  // Edge sums are widened to 11 bits so nothing wraps near the screen edge.
  logic [10:0] ball_right;
  logic [10:0] ball_bottom;
  logic [10:0] lp_bottom;
  logic [10:0] rp_bottom;

  assign ball_right  = {1'b0, ball_x} + {3'b000, ball_size_x};
  assign ball_bottom = {1'b0, ball_y} + {3'b000, ball_size_y};
  assign lp_bottom   = {1'b0, left_paddle_y}  + 11'(PADDLE_H);
  assign rp_bottom   = {1'b0, right_paddle_y} + 11'(PADDLE_H);

  logic goal_right;  // right player scores
  logic goal_left;   // left player scores
  logic goal_any;
  logic wall;
  logic hit_left;
  logic hit_right;

  assign goal_right = (ball_x == 10'd0);
  assign goal_left  = (ball_right >= 11'(SCREEN_X));
  assign goal_any   = goal_right | goal_left;
  assign wall       = (ball_y == 10'd0) || (ball_bottom >= 11'(SCREEN_Y));

  assign hit_left  = ({1'b0, ball_x} < 11'(LEFT_PADDLE_X + PADDLE_W)) &&
                     (ball_right > 11'(LEFT_PADDLE_X)) &&
                     ({1'b0, ball_y} < lp_bottom) &&
                     (ball_bottom > {1'b0, left_paddle_y});

  assign hit_right = ({1'b0, ball_x} < 11'(RIGHT_PADDLE_X + PADDLE_W)) &&
                     (ball_right > 11'(RIGHT_PADDLE_X)) &&
                     ({1'b0, ball_y} < rp_bottom) &&
                     (ball_bottom > {1'b0, right_paddle_y});

  // If both goal lines trip at once the right player is credited.
  logic [3:0] scorer_score;
  logic [3:0] scorer_new;

  assign scorer_score = goal_right ? score_right : score_left;
  assign scorer_new   = (scorer_score < 4'(MAX_SCORE)) ? scorer_score + 4'd1
                                                       : scorer_score;

  // In HOLD a goal is still honoured; once holdoff has run down to zero the
  // tick is evaluated exactly like PLAY.
  logic eval_now;
  assign eval_now = (state == ST_PLAY) ||
                    ((state == ST_HOLD) && (goal_any || (holdoff_cnt == 8'd0)));

  logic [1:0] state_n;
  logic [1:0] bounce_n;
  logic [7:0] holdoff_n;
  logic [7:0] serve_n;
  logic [3:0] score_left_n;
  logic [3:0] score_right_n;

  always_comb begin
    state_n       = state;
    bounce_n      = B_NONE;
    holdoff_n     = holdoff_cnt;
    serve_n       = serve_cnt;
    score_left_n  = score_left;
    score_right_n = score_right;

    if (state == ST_SERVE) begin
      if (serve_cnt == 8'd0) begin
        state_n = ST_PLAY;
      end else begin
        serve_n = serve_cnt - 8'd1;
      end
    end else if (state == ST_OVER) begin
      state_n = ST_OVER;
    end else if (eval_now) begin
      if (goal_any) begin
        bounce_n = B_GOAL;
        if (goal_right) begin
          score_right_n = scorer_new;
        end else begin
          score_left_n = scorer_new;
        end
        if (scorer_new == 4'(MAX_SCORE)) begin
          state_n = ST_OVER;
        end else begin
          state_n = ST_SERVE;
          serve_n = 8'(SERVE_DELAY);
        end
      end else if (hit_left || hit_right) begin
        // Corner wall+paddle lands here: paddle outranks wall.
        bounce_n  = B_PADDLE;
        holdoff_n = 8'(HOLDOFF);
        state_n   = ST_HOLD;
      end else if (wall) begin
        bounce_n  = B_WALL;
        holdoff_n = 8'(HOLDOFF);
        state_n   = ST_HOLD;
      end else begin
        state_n = ST_PLAY;
      end
    end else begin
      // HOLD with holdoff still running: wall/paddle ignored.
      holdoff_n = holdoff_cnt - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_PLAY;
      bounce      <= B_NONE;
      holdoff_cnt <= 8'd0;
      serve_cnt   <= 8'd0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      serving     <= 1'b0;
      game_over   <= 1'b0;
    end else if (frame_tick) begin
      state       <= state_n;
      bounce      <= bounce_n;
      holdoff_cnt <= holdoff_n;
      serve_cnt   <= serve_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
      serving     <= (state_n == ST_SERVE);
      game_over   <= (state_n == ST_OVER);
    end
  end

  assign debug_state = state;

endmodule
